// File: rtl/io_port_sched.sv
// Purpose: four 1-entry input buffers with a shared round-robin capture path, plus four 1-entry output buffers for CPU port I/O.
// Latency: a captured byte is readable the cycle after capture; a CPU write is visible on out_valid/out_data the cycle after.
// Backpressure: io_stall holds a read of an empty input buffer or a write to a full, unaccepted output buffer; in_ready grants at most one port per cycle.
module io_port_sched #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [1:0]      io_addr,
    input  logic [DW-1:0]   io_wdata,
    output logic [DW-1:0]   io_rdata,
    output logic            io_stall,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic [3:0]      out_valid,
    output logic [4*DW-1:0] out_data,
    input  logic [3:0]      out_ready
);

    logic [DW-1:0] in_buf  [4];
    logic [DW-1:0] out_buf [4];
    logic [3:0]    in_full;
    logic [1:0]    rr;

    logic [3:0] cand;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic [1:0] idx;
    logic       found;
    logic [3:0] cap;
    logic       rd_hit;
    logic       rd_stall;
    logic       wr_stall;
    logic       wr_ok;

    assign rd_hit = io_rd & in_full[io_addr];

    // A full buffer being read this cycle may refill on the same edge.
    always_comb begin
        cand = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = (in_valid[i] & ~in_full[i])
                    | (in_full[i] & io_rd & (io_addr == 2'(i)));
        end
    end

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && cand[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    assign in_ready = reset ? grant : 4'b0000;
    assign cap      = in_ready & in_valid;

    assign rd_stall = reset & io_rd & ~in_full[io_addr];
    // A simultaneous read wins, so the write path neither stalls nor commits.
    assign wr_stall = reset & io_wr & ~io_rd & out_valid[io_addr] & ~out_ready[io_addr];
    assign wr_ok    = io_wr & ~io_rd & (~out_valid[io_addr] | out_ready[io_addr]);
    assign io_stall = rd_stall | wr_stall;
    assign io_rdata = (reset && rd_hit) ? in_buf[io_addr] : '0;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign out_data[g*DW +: DW] = out_buf[g];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_full   <= '0;
            out_valid <= '0;
            rr        <= '0;
            for (int i = 0; i < 4; i++) begin
                in_buf[i]  <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) begin
                    in_buf[i]  <= in_data[i*DW +: DW];
                    in_full[i] <= 1'b1;
                end else if (rd_hit && io_addr == 2'(i)) begin
                    in_full[i] <= 1'b0;
                end

                if (wr_ok && io_addr == 2'(i)) begin
                    out_buf[i]   <= io_wdata;
                    out_valid[i] <= 1'b1;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (|cap) begin
                rr <= gidx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_sched.sv
// Directed table of per-cycle stimulus and expected outputs for io_port_sched, plus short hand-written sequences.
module tb_io_port_sched;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            io_rd;
    logic            io_wr;
    logic [1:0]      io_addr;
    logic [DW-1:0]   io_wdata;
    logic [DW-1:0]   io_rdata;
    logic            io_stall;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic [3:0]      out_valid;
    logic [4*DW-1:0] out_data;
    logic [3:0]      out_ready;

    int checks = 0;
    int errors = 0;

    io_port_sched #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_stall  (io_stall),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic [3:0]  iv;
        logic [3:0]  orr;
        logic        chk_ir;
        logic [3:0]  ir;
        logic        stall;
        logic [7:0]  rdata;
        logic [3:0]  ov;
        logic [31:0] od;
    } vec_t;

    localparam int NV = 35;
    vec_t tbl [NV];

    function automatic vec_t mk(logic rst, logic rd, logic wr, logic [1:0] addr, logic [7:0] wdata,
                                logic [3:0] iv, logic [3:0] orr, logic chk_ir, logic [3:0] ir,
                                logic stall, logic [7:0] rdata, logic [3:0] ov, logic [31:0] od);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.iv = iv; v.orr = orr; v.chk_ir = chk_ir; v.ir = ir;
        v.stall = stall; v.rdata = rdata; v.ov = ov; v.od = od;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        io_rd = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_wdata = '0;
        in_valid = 4'b0000; out_ready = 4'b0000;
    endtask

    initial begin
        //               rst rd wr addr wdata  iv       orr     chk ir       st rdata  ov       od
        tbl[0]  = mk(0, 1, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[1]  = mk(0, 0, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[2]  = mk(1, 0, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b0001, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[3]  = mk(1, 0, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b0010, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[4]  = mk(1, 0, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b0100, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[5]  = mk(1, 0, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b1000, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[6]  = mk(1, 0, 0, 2'd0, 8'h00, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 32'h00000000);
        // read and write together on port 1: the read wins
        tbl[7]  = mk(1, 1, 1, 2'd1, 8'hAA, 4'b0010, 4'b0000, 1, 4'b0010, 0, 8'h08, 4'b0000, 32'h00000000);
        tbl[8]  = mk(1, 1, 0, 2'd0, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[9]  = mk(1, 1, 0, 2'd1, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h08, 4'b0000, 32'h00000000);
        tbl[10] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h05, 4'b0000, 32'h00000000);
        tbl[11] = mk(1, 1, 0, 2'd3, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h80, 4'b0000, 32'h00000000);
        // rr=2 with only ports 0,1 valid: wrap to 0, then 1
        tbl[12] = mk(1, 0, 0, 2'd0, 8'h00, 4'b0011, 4'b0000, 1, 4'b0001, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[13] = mk(1, 0, 0, 2'd0, 8'h00, 4'b0011, 4'b0000, 1, 4'b0010, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[14] = mk(1, 0, 0, 2'd0, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[15] = mk(1, 1, 0, 2'd0, 8'h00, 4'b0101, 4'b0000, 1, 4'b0100, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[16] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h05, 4'b0000, 32'h00000000);
        // read of empty port 2, byte arrives three cycles later
        tbl[17] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b0000, 32'h00000000);
        tbl[18] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b0000, 32'h00000000);
        tbl[19] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b0000, 32'h00000000);
        tbl[20] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0100, 4'b0000, 1, 4'b0100, 1, 8'h00, 4'b0000, 32'h00000000);
        tbl[21] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h05, 4'b0000, 32'h00000000);
        tbl[22] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b0000, 32'h00000000);
        // write stall on port 3, then simultaneous drain and reload
        tbl[23] = mk(1, 0, 1, 2'd3, 8'h11, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 32'h00000000);
        tbl[24] = mk(1, 0, 1, 2'd3, 8'h80, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b1000, 32'h11000000);
        tbl[25] = mk(1, 0, 1, 2'd3, 8'h80, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b1000, 32'h11000000);
        tbl[26] = mk(1, 0, 1, 2'd3, 8'h80, 4'b0000, 4'b1000, 1, 4'b0000, 0, 8'h00, 4'b1000, 32'h11000000);
        tbl[27] = mk(1, 0, 0, 2'd0, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b1000, 32'h80000000);
        tbl[28] = mk(1, 0, 0, 2'd0, 8'h00, 4'b0000, 4'b1000, 1, 4'b0000, 0, 8'h00, 4'b1000, 32'h80000000);
        tbl[29] = mk(1, 0, 0, 2'd0, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 32'h80000000);
        tbl[30] = mk(1, 0, 1, 2'd0, 8'h5A, 4'b1111, 4'b0000, 1, 4'b1000, 0, 8'h00, 4'b0000, 32'h80000000);
        // reset mid-stall with buffers full
        tbl[31] = mk(1, 1, 0, 2'd2, 8'h00, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8'h00, 4'b0001, 32'h8000005A);
        tbl[32] = mk(0, 1, 1, 2'd2, 8'h33, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h00, 4'b0001, 32'h8000005A);
        tbl[33] = mk(1, 1, 0, 2'd3, 8'h00, 4'b0010, 4'b0000, 1, 4'b0010, 1, 8'h00, 4'b0000, 32'h00000000);
        tbl[34] = mk(1, 1, 0, 2'd1, 8'h00, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h08, 4'b0000, 32'h00000000);

        reset = 1'b0;
        idle_inputs();
        in_data = 32'h80050800;
        repeat (2) @(posedge clk);

        for (int r = 0; r < NV; r++) begin
            @(posedge clk);
            #1;
            reset     = tbl[r].rst;
            io_rd     = tbl[r].rd;
            io_wr     = tbl[r].wr;
            io_addr   = tbl[r].addr;
            io_wdata  = tbl[r].wdata;
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].orr;
            #3;
            if (tbl[r].chk_ir) check("in_ready", r, 32'(in_ready), 32'(tbl[r].ir));
            check("io_stall", r, 32'(io_stall), 32'(tbl[r].stall));
            check("io_rdata", r, 32'(io_rdata), 32'(tbl[r].rdata));
            check("out_valid", r, 32'(out_valid), 32'(tbl[r].ov));
            check("out_data", r, out_data, tbl[r].od);
        end

        // out_data held stable while the consumer refuses
        @(posedge clk); #1;
        idle_inputs();
        io_wr = 1'b1; io_addr = 2'd2; io_wdata = 8'h33;
        @(posedge clk); #1;
        idle_inputs();
        io_wr = 1'b1; io_addr = 2'd2; io_wdata = 8'h44;
        for (int c = 0; c < 3; c++) begin
            #3;
            check("hold_stall", 100 + c, 32'(io_stall), 32'd1);
            check("hold_data", 100 + c, 32'(out_data[23:16]), 32'h33);
            check("hold_valid", 100 + c, 32'(out_valid), 32'b0100);
            @(posedge clk); #1;
        end

        // read of empty port 0 completes once a byte is captured
        idle_inputs();
        io_rd = 1'b1; io_addr = 2'd0;
        in_data = 32'h00000077;
        @(posedge clk); #1;
        in_valid = 4'b0001;
        begin
            int budget;
            budget = 10;
            #3;
            while (io_stall && budget > 0) begin
                @(posedge clk); #1;
                in_valid = 4'b0000;
                #3;
                budget--;
            end
            check("rd_wait_timeout", 200, 32'(budget > 0), 32'd1);
            check("rd_wait_data", 200, 32'(io_rdata), 32'h77);
        end
        @(posedge clk); #1;
        #3;
        check("rd_cleared", 201, 32'(io_stall), 32'd1);

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_sched.md
IO_PORT_SCHED -- requirements
Module: io_port_sched

Interface
REQ-001 Parameter: DW, default 8, data width of every port byte.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 io_rd  input  1  CPU read strobe for input port io_addr.
REQ-005 io_wr  input  1  CPU write strobe for output port io_addr.
REQ-006 io_addr  input  2  port select 0..3.
REQ-007 io_wdata  input  DW  CPU write data.
REQ-008 io_rdata  output  DW  CPU read data, combinational.
REQ-009 io_stall  output  1  CPU shall hold its strobe and address while high.
REQ-010 in_valid  input  4  peripheral i offers a byte.
REQ-011 in_data  input  4*DW  byte for port i at bits [i*DW +: DW].
REQ-012 in_ready  output  4  one-hot or zero grant; byte i captured when in_valid[i] & in_ready[i].
REQ-013 out_valid  output  4  output buffer i holds a byte.
REQ-014 out_data  output  4*DW  output buffer i at bits [i*DW +: DW].
REQ-015 out_ready  input  4  consumer i accepts; transfer when out_valid[i] & out_ready[i].

Function
REQ-016 Four 1-entry input buffers (in_buf[i], in_full[i]) share a single capture path, with at most one capture per cycle.
REQ-017 Candidates: ports with in_valid[i]=1 and in_full[i]=0, or with in_full[i]=1 being read this cycle.
REQ-018 Grant: round-robin starting at pointer rr (2 bits); first candidate at rr, rr+1, ... mod 4; in_ready is one-hot on that port, or 0 if there are no candidates.
REQ-019 After a capture on port g: rr <= g+1 mod 4 (wraps 3 -> 0); rr is unchanged when no capture occurs.
REQ-020 in_ready is combinational from in_valid, in_full, rr and the read strobe; it does not depend on in_ready of other ports.
REQ-021 CPU read, io_rd=1 and in_full[io_addr]=1: io_rdata = in_buf[io_addr], io_stall=0, in_full cleared at the edge unless a capture to the same port occurs that edge, in which case the buffer holds the new byte and stays full.
REQ-022 CPU read with an empty buffer: io_stall=1, io_rdata=0; the read completes in the first cycle after a capture into that port (minimum latency 1 cycle from capture).
REQ-023 io_rdata = 0 whenever io_rd=0.
REQ-024 CPU write, io_wr=1 and io_rd=0: accepted when out_valid[io_addr]=0 or out_ready[io_addr]=1 that cycle; out_buf loaded and out_valid set at the edge; io_stall=0.
REQ-025 CPU write to a full buffer with out_ready=0: io_stall=1, no buffer change.
REQ-026 Consumer accept without a simultaneous CPU write to that port: out_valid[i] cleared at the edge.
REQ-027 io_rd and io_wr both high: the read is performed and the write is ignored; io_stall reflects the read only.
REQ-028 io_stall = read-stall OR write-stall, combinational.
REQ-029 out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.

Reset
REQ-030 reset=0 at an edge: in_full=0, out_valid=0, in_buf=0, out_buf=0, rr=0.
REQ-031 While reset=0: in_ready=0, io_stall=0, io_rdata=0; in-flight strobes and handshakes are discarded.
REQ-032 The first capture is possible in the cycle after reset returns to 1.

Verification
REQ-033 After reset, in_valid=4'b1111 with bytes 0,8,5,128 on ports 0..3, no reads -> in_ready grants 0,1,2,3 on successive cycles; then in_ready=0 and in_full=4'b1111.
REQ-034 rr=2, in_valid=4'b0011, all empty -> grant port 0, then port 1, then rr=2.
REQ-035 io_rd, io_addr=2, port 2 empty; port 2 presents 5 three cycles later -> io_stall=1 until the capture; in the next cycle io_rdata=5, io_stall=0, in_full[2] cleared.
REQ-036 io_wr to port 3 with 128 while out_valid[3]=1 and out_ready[3]=0 for 2 cycles -> io_stall=1 for 2 cycles; when out_ready[3]=1, the old byte transfers and 128 loads in the same cycle, and out_valid[3] stays 1.
REQ-037 io_rd and io_wr both to port 1 with in_buf[1]=8 -> io_rdata=8, out buffer 1 unchanged.
REQ-038 reset=0 asserted mid-stall with buffers full -> all flags cleared at the next edge; io_stall=0.
